// File: rtl/tdm_demux_1x4_if.sv
// Signal bundle between the TDM sample source and the 1:4 demultiplexer.
// The master drives the sample stream and the slave returns the rebuilt channels.
interface tdm_demux_1x4_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] ch_a;
    logic [WIDTH-1:0] ch_b;
    logic [WIDTH-1:0] ch_c;
    logic [WIDTH-1:0] ch_d;
    logic             frame_done;
    logic             sync_err;
    logic             locked;
    logic [1:0]       slot;

    modport master (
        output din, din_valid, frame_sync,
        input  ch_a, ch_b, ch_c, ch_d, frame_done, sync_err, locked, slot
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch_a, ch_b, ch_c, ch_d, frame_done, sync_err, locked, slot
    );
endinterface

// File: rtl/tdm_demux_1x4.sv
// Receive side of a 4:1 TDM link: collects slots a..d into shadow registers and
// publishes all four channels together once a complete frame has arrived.
module tdm_demux_1x4 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    tdm_demux_1x4_if.slave   bus
);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow_q [3];
    logic [WIDTH-1:0] shadow_d [3];
    logic [WIDTH-1:0] chan_q [4];
    logic [WIDTH-1:0] chan_d [4];
    logic             frame_done_q, frame_done_d;
    logic             sync_err_q, sync_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= UNLOCKED;
            slot_q       <= 2'd0;
            shadow_q     <= '{default: '0};
            chan_q       <= '{default: '0};
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            chan_q       <= chan_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Slot 3 needs no shadow: its sample goes straight to ch_d on the publish edge.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        chan_d       = chan_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (bus.din_valid) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (bus.frame_sync) begin
                        shadow_d[0] = bus.din;
                        slot_d      = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.frame_sync && (slot_q != 2'd0)) begin
                        sync_err_d  = 1'b1;
                        shadow_d[0] = bus.din;
                        slot_d      = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd0: shadow_d[0] = bus.din;
                            2'd1: shadow_d[1] = bus.din;
                            2'd2: shadow_d[2] = bus.din;
                            default: begin
                                chan_d[0]    = shadow_q[0];
                                chan_d[1]    = shadow_q[1];
                                chan_d[2]    = shadow_q[2];
                                chan_d[3]    = bus.din;
                                frame_done_d = 1'b1;
                            end
                        endcase
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    assign bus.ch_a       = chan_q[0];
    assign bus.ch_b       = chan_q[1];
    assign bus.ch_c       = chan_q[2];
    assign bus.ch_d       = chan_q[3];
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Table-driven bench for tdm_demux_1x4: each vector's expectation is queued when
// it is driven and popped once the DUT has clocked that vector in.
module tb_tdm_demux_1x4;

    localparam int W = 3;

    typedef struct packed {
        logic         rst_n;
        logic         din_valid;
        logic         frame_sync;
        logic [W-1:0] din;
        logic [W-1:0] ch_a;
        logic [W-1:0] ch_b;
        logic [W-1:0] ch_c;
        logic [W-1:0] ch_d;
        logic         frame_done;
        logic         sync_err;
        logic         locked;
        logic [1:0]   slot;
    } vec_t;

    logic clk;
    logic rst_n;

    tdm_demux_1x4_if #(.WIDTH(W)) bus ();

    tdm_demux_1x4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t vecs [$];
    vec_t exp_q [$];
    int   vectors_applied = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int r, input int v, input int s, input int d,
                       input int a, input int b, input int c, input int dd,
                       input int fd, input int se, input int lk, input int sl);
        vec_t t;
        t.rst_n      = 1'(r);
        t.din_valid  = 1'(v);
        t.frame_sync = 1'(s);
        t.din        = W'(d);
        t.ch_a       = W'(a);
        t.ch_b       = W'(b);
        t.ch_c       = W'(c);
        t.ch_d       = W'(dd);
        t.frame_done = 1'(fd);
        t.sync_err   = 1'(se);
        t.locked     = 1'(lk);
        t.slot       = 2'(sl);
        vecs.push_back(t);
    endtask

    task automatic cmpField(input int idx, input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL vec %0d %s: got %0d, expected %0d", idx, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n          = v.rst_n;
        bus.din_valid  = v.din_valid;
        bus.frame_sync = v.frame_sync;
        bus.din        = v.din;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        vectors_applied++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL vec %0d scoreboard: got empty queue, expected an entry", idx);
            return;
        end
        e = exp_q.pop_front();
        cmpField(idx, "ch_a",       int'(bus.ch_a),       int'(e.ch_a));
        cmpField(idx, "ch_b",       int'(bus.ch_b),       int'(e.ch_b));
        cmpField(idx, "ch_c",       int'(bus.ch_c),       int'(e.ch_c));
        cmpField(idx, "ch_d",       int'(bus.ch_d),       int'(e.ch_d));
        cmpField(idx, "frame_done", int'(bus.frame_done), int'(e.frame_done));
        cmpField(idx, "sync_err",   int'(bus.sync_err),   int'(e.sync_err));
        cmpField(idx, "locked",     int'(bus.locked),     int'(e.locked));
        cmpField(idx, "slot",       int'(bus.slot),       int'(e.slot));
        cmpField(idx, "done_and_err", int'(bus.frame_done & bus.sync_err), 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        bus.din        = '0;

        //   rst v  s  din  a  b  c  d  fd se lk sl
        // Reset state
        add(0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 1, 5,   0, 0, 0, 0,  0, 0, 0, 0);
        // 1: synced frame 1,2,3,0
        add(1, 1, 1, 1,   0, 0, 0, 0,  0, 0, 1, 1);
        add(1, 1, 0, 2,   0, 0, 0, 0,  0, 0, 1, 2);
        add(1, 1, 0, 3,   0, 0, 0, 0,  0, 0, 1, 3);
        add(1, 1, 0, 0,   1, 2, 3, 0,  1, 0, 1, 0);
        add(1, 0, 0, 0,   1, 2, 3, 0,  0, 0, 1, 0);
        // 2: unsynced samples dropped, sync without valid ignored, then frame 0..3
        add(0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 1, 0, 3,   0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 1, 0, 3,   0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 0, 1, 5,   0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 1, 1, 0,   0, 0, 0, 0,  0, 0, 1, 1);
        add(1, 1, 0, 1,   0, 0, 0, 0,  0, 0, 1, 2);
        add(1, 1, 0, 2,   0, 0, 0, 0,  0, 0, 1, 3);
        add(1, 1, 0, 3,   0, 1, 2, 3,  1, 0, 1, 0);
        // 3: frame 1,1,1,1 then early sync after 2,2
        add(1, 1, 1, 1,   0, 1, 2, 3,  0, 0, 1, 1);
        add(1, 1, 0, 1,   0, 1, 2, 3,  0, 0, 1, 2);
        add(1, 1, 0, 1,   0, 1, 2, 3,  0, 0, 1, 3);
        add(1, 1, 0, 1,   1, 1, 1, 1,  1, 0, 1, 0);
        add(1, 1, 0, 2,   1, 1, 1, 1,  0, 0, 1, 1);
        add(1, 1, 0, 2,   1, 1, 1, 1,  0, 0, 1, 2);
        add(1, 1, 1, 3,   1, 1, 1, 1,  0, 1, 1, 1);
        add(1, 1, 0, 0,   1, 1, 1, 1,  0, 0, 1, 2);
        add(1, 1, 0, 1,   1, 1, 1, 1,  0, 0, 1, 3);
        add(1, 1, 0, 2,   3, 0, 1, 2,  1, 0, 1, 0);
        add(1, 0, 0, 0,   3, 0, 1, 2,  0, 0, 1, 0);
        // 4: frame 1,2,3,0 with two idle cycles between samples
        add(1, 1, 1, 1,   3, 0, 1, 2,  0, 0, 1, 1);
        add(1, 0, 0, 7,   3, 0, 1, 2,  0, 0, 1, 1);
        add(1, 0, 1, 7,   3, 0, 1, 2,  0, 0, 1, 1);
        add(1, 1, 0, 2,   3, 0, 1, 2,  0, 0, 1, 2);
        add(1, 0, 0, 0,   3, 0, 1, 2,  0, 0, 1, 2);
        add(1, 0, 0, 0,   3, 0, 1, 2,  0, 0, 1, 2);
        add(1, 1, 0, 3,   3, 0, 1, 2,  0, 0, 1, 3);
        add(1, 0, 0, 0,   3, 0, 1, 2,  0, 0, 1, 3);
        add(1, 0, 0, 0,   3, 0, 1, 2,  0, 0, 1, 3);
        add(1, 1, 0, 0,   1, 2, 3, 0,  1, 0, 1, 0);
        add(1, 0, 0, 0,   1, 2, 3, 0,  0, 0, 1, 0);
        // 5: reset mid-frame, then unsynced samples dropped
        add(1, 1, 1, 4,   1, 2, 3, 0,  0, 0, 1, 1);
        add(1, 1, 0, 5,   1, 2, 3, 0,  0, 0, 1, 2);
        add(0, 1, 0, 6,   0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 1, 0, 6,   0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 1, 0, 7,   0, 0, 0, 0,  0, 0, 0, 0);
        // 6: back-to-back frames, second freewheels without sync
        add(1, 1, 1, 1,   0, 0, 0, 0,  0, 0, 1, 1);
        add(1, 1, 0, 2,   0, 0, 0, 0,  0, 0, 1, 2);
        add(1, 1, 0, 3,   0, 0, 0, 0,  0, 0, 1, 3);
        add(1, 1, 0, 4,   1, 2, 3, 4,  1, 0, 1, 0);
        add(1, 1, 0, 5,   1, 2, 3, 4,  0, 0, 1, 1);
        add(1, 1, 0, 6,   1, 2, 3, 4,  0, 0, 1, 2);
        add(1, 1, 0, 7,   1, 2, 3, 4,  0, 0, 1, 3);
        add(1, 1, 0, 4,   5, 6, 7, 4,  1, 0, 1, 0);
        add(1, 0, 0, 0,   5, 6, 7, 4,  0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(i);
        end

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
